// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) arbiter onto one SRAM-like slave. Data wins ties, a stalled
// grant stays locked until it is accepted, and responses are routed back in order.
module sram_like_arbiter #(
  parameter int OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,

  output logic        arb_err
);

  localparam logic [2:0] DEPTH    = 3'(OUTST);
  localparam logic [1:0] LAST_PTR = 2'(OUTST - 1);

  logic       lock_q, lock_d;
  logic       lock_id_q, lock_id_d;
  logic [3:0] fifo_q, fifo_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       arb_err_q, arb_err_d;

  logic own_vld, own_id;
  logic push, pop, head_id;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // Owner ID: 0 = inst, 1 = data
  always_comb begin
    own_vld = 1'b0;
    own_id  = 1'b0;
    if (lock_q) begin
      own_vld = 1'b1;
      own_id  = lock_id_q;
    end else if (data_sram_req) begin
      own_vld = 1'b1;
      own_id  = 1'b1;
    end else if (inst_sram_req) begin
      own_vld = 1'b1;
      own_id  = 1'b0;
    end
  end

  always_comb begin
    sram_wr    = 1'b0;
    sram_size  = 2'd0;
    sram_wstrb = 4'd0;
    sram_addr  = 32'd0;
    sram_wdata = 32'd0;
    if (own_vld) begin
      if (own_id) begin
        sram_wr    = data_sram_wr;
        sram_size  = data_sram_size;
        sram_wstrb = data_sram_wstrb;
        sram_addr  = data_sram_addr;
        sram_wdata = data_sram_wdata;
      end else begin
        sram_wr    = inst_sram_wr;
        sram_size  = inst_sram_size;
        sram_wstrb = inst_sram_wstrb;
        sram_addr  = inst_sram_addr;
        sram_wdata = inst_sram_wdata;
      end
    end
  end

  // Full is judged on the registered count, so a same-cycle response never unblocks a request.
  // resetn gating keeps every handshake quiet while reset is held.
  always_comb begin
    sram_req          = resetn & own_vld & (cnt_q < DEPTH);
    push              = sram_req & sram_addr_ok;
    inst_sram_addr_ok = push & ~own_id;
    data_sram_addr_ok = push & own_id;

    head_id           = fifo_q[rd_ptr_q];
    pop               = resetn & sram_data_ok & (cnt_q != 3'd0);
    inst_sram_data_ok = pop & ~head_id;
    data_sram_data_ok = pop & head_id;

    inst_sram_rdata   = sram_rdata;
    data_sram_rdata   = sram_rdata;
    arb_err           = arb_err_q;
  end

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    arb_err_d = arb_err_q | (sram_data_ok & (cnt_q == 3'd0));

    if (push) begin
      lock_d = 1'b0;
    end else if (sram_req) begin
      lock_d    = 1'b1;
      lock_id_d = own_id;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = own_id;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      fifo_q    <= 4'd0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      cnt_q     <= 3'd0;
      arb_err_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      arb_err_q <= arb_err_d;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter (OUTST = 2): table of single-cycle grant
// vectors plus hand-written lock / ordering / full / spurious / reset sequences.
module tb_sram_like_arbiter;

  localparam logic [31:0] I_WDATA = 32'hAAAA_0000;
  localparam logic [31:0] D_WDATA = 32'h0000_5555;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_req = 1'b0, inst_sram_wr, data_sram_req = 1'b0, data_sram_wr;
  logic [1:0]  inst_sram_size, data_sram_size;
  logic [3:0]  inst_sram_wstrb, data_sram_wstrb;
  logic [31:0] inst_sram_addr = 32'd0, inst_sram_wdata, data_sram_addr = 32'd0, data_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic        sram_req, sram_wr, sram_addr_ok = 1'b0, sram_data_ok = 1'b0, arb_err;
  logic [1:0]  sram_size;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_addr, sram_wdata, sram_rdata = 32'd0;

  int checks = 0;
  int errors = 0;
  logic sb[$];

  sram_like_arbiter #(.OUTST(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_wstrb(sram_wstrb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic        ireq, dreq, aok;
    logic [31:0] iaddr, daddr;
    logic        exp_req, exp_wr, exp_iok, exp_dok;
    logic [31:0] exp_addr, exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    sram_addr_ok = 1'b0;
    sram_data_ok = 1'b0;
  endtask

  task automatic do_reset();
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    sram_addr_ok  = 1'b0;
    sram_data_ok  = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
  endtask

  // Slave returns one response; the scoreboard says which master must see it.
  task automatic respond(input string name, input logic [31:0] v);
    logic id;
    sram_data_ok = 1'b1;
    sram_rdata   = v;
    #1;
    if (sb.size() == 0) begin
      chk({name, " inst_data_ok"}, 32'(inst_sram_data_ok), 32'd0);
      chk({name, " data_data_ok"}, 32'(data_sram_data_ok), 32'd0);
    end else begin
      id = sb.pop_front();
      chk({name, " inst_data_ok"}, 32'(inst_sram_data_ok), 32'(!id));
      chk({name, " data_data_ok"}, 32'(data_sram_data_ok), 32'(id));
      chk({name, " rdata"}, id ? data_sram_rdata : inst_sram_rdata, v);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"idle",       0, 0, 1, 32'h100, 32'h1000, 0, 0, 0, 0, 32'h0,   32'h0};
    vecs[1] = '{"inst_only",  1, 0, 1, 32'h100, 32'h1000, 1, 0, 1, 0, 32'h100, I_WDATA};
    vecs[2] = '{"data_only",  0, 1, 1, 32'h100, 32'h1000, 1, 1, 0, 1, 32'h1000, D_WDATA};
    vecs[3] = '{"priority",   1, 1, 1, 32'h100, 32'h1000, 1, 1, 0, 1, 32'h1000, D_WDATA};
    vecs[4] = '{"both_stall", 1, 1, 0, 32'h100, 32'h1000, 1, 1, 0, 0, 32'h1000, D_WDATA};
    vecs[5] = '{"inst_stall", 1, 0, 0, 32'h200, 32'h1000, 1, 0, 0, 0, 32'h200, I_WDATA};

    inst_sram_wr = 1'b0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'hF; inst_sram_wdata = I_WDATA;
    data_sram_wr = 1'b1; data_sram_size = 2'd1; data_sram_wstrb = 4'h3; data_sram_wdata = D_WDATA;

    // Handshakes stay quiet while reset is held, even with requests and responses present.
    data_sram_req = 1'b1; sram_addr_ok = 1'b1; sram_data_ok = 1'b1;
    #2;
    chk("rst sram_req", 32'(sram_req), 32'd0);
    chk("rst data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
    chk("rst inst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    chk("rst data_data_ok", 32'(data_sram_data_ok), 32'd0);
    chk("rst arb_err", 32'(arb_err), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      next();
      inst_sram_req  = vecs[i].ireq;
      data_sram_req  = vecs[i].dreq;
      inst_sram_addr = vecs[i].iaddr;
      data_sram_addr = vecs[i].daddr;
      sram_addr_ok   = vecs[i].aok;
      #1;
      chk({vecs[i].name, " sram_req"}, 32'(sram_req), 32'(vecs[i].exp_req));
      chk({vecs[i].name, " sram_addr"}, sram_addr, vecs[i].exp_addr);
      chk({vecs[i].name, " sram_wdata"}, sram_wdata, vecs[i].exp_wdata);
      chk({vecs[i].name, " sram_wr"}, 32'(sram_wr), 32'(vecs[i].exp_wr));
      chk({vecs[i].name, " inst_addr_ok"}, 32'(inst_sram_addr_ok), 32'(vecs[i].exp_iok));
      chk({vecs[i].name, " data_addr_ok"}, 32'(data_sram_addr_ok), 32'(vecs[i].exp_dok));
    end

    // Lock: stalled inst grant holds the bus while data arrives.
    do_reset();
    next(); inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0000; #1;
    chk("lock c1 addr", sram_addr, 32'hBFC0_0000);
    chk("lock c1 inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    next(); data_sram_req = 1'b1; data_sram_addr = 32'h1000; #1;
    chk("lock c2 addr", sram_addr, 32'hBFC0_0000);
    chk("lock c2 data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
    next(); #1;
    chk("lock c3 addr", sram_addr, 32'hBFC0_0000);
    next(); sram_addr_ok = 1'b1; #1;
    chk("lock acc addr", sram_addr, 32'hBFC0_0000);
    chk("lock acc inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    chk("lock acc data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
    sb.push_back(1'b0);
    next(); inst_sram_req = 1'b0; sram_addr_ok = 1'b1; #1;
    chk("after lock addr", sram_addr, 32'h1000);
    chk("after lock data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
    sb.push_back(1'b1);

    // Full: two outstanding, a third data request must wait for a response cycle to pass.
    next(); data_sram_addr = 32'h2000; sram_addr_ok = 1'b1; #1;
    chk("full sram_req", 32'(sram_req), 32'd0);
    chk("full data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
    next(); sram_addr_ok = 1'b1;
    respond("order1", 32'h11);
    chk("full same-cycle sram_req", 32'(sram_req), 32'd0);
    next(); sram_addr_ok = 1'b1; #1;
    chk("unfull sram_req", 32'(sram_req), 32'd1);
    chk("unfull addr", sram_addr, 32'h2000);
    chk("unfull data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
    sb.push_back(1'b1);
    next(); data_sram_req = 1'b0;
    respond("order2", 32'h22);
    next();
    respond("order3", 32'h33);

    // Spurious response with nothing outstanding.
    next();
    respond("spurious", 32'h44);
    next(); #1;
    chk("spurious arb_err", 32'(arb_err), 32'd1);
    next(); next(); #1;
    chk("arb_err sticky", 32'(arb_err), 32'd1);
    resetn = 1'b0; #1;
    chk("arb_err cleared by reset", 32'(arb_err), 32'd0);
    @(negedge clk); resetn = 1'b1;

    // Reset with one outstanding and a data lock pending.
    next(); inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0000; sram_addr_ok = 1'b1; #1;
    chk("midrst accept", 32'(inst_sram_addr_ok), 32'd1);
    next(); inst_sram_req = 1'b0; data_sram_req = 1'b1; data_sram_addr = 32'h1000; #1;
    chk("midrst stall req", 32'(sram_req), 32'd1);
    next(); sram_addr_ok = 1'b1; #1;
    resetn = 1'b0; #1;
    chk("midrst sram_req", 32'(sram_req), 32'd0);
    chk("midrst data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
    next(); resetn = 1'b1; data_sram_req = 1'b0; inst_sram_req = 1'b1; #1;
    chk("postrst lock clear addr", sram_addr, 32'hBFC0_0000);
    chk("postrst sram_req", 32'(sram_req), 32'd1);
    next(); inst_sram_req = 1'b0;
    sb.delete();
    respond("stale resp", 32'h55);
    next(); #1;
    chk("stale arb_err", 32'(arb_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
